// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - sequential signed dot-product MAC over one LEN-sample window
module conv_mac #(
    parameter  int LEN  = 4,
    parameter  int DW   = 8,
    localparam int ACCW = 2*DW + $clog2(LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LEN*DW-1:0]   in_data,
    input  logic [LEN*DW-1:0]   in_kernel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ACCW-1:0]     out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    // Index width kept at least 1 so LEN=1 still has a legal counter.
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_in_ready;
    logic [LEN*DW-1:0]         r_data;
    logic [LEN*DW-1:0]         r_kernel;
    logic [IW-1:0]             r_idx;
    logic signed [ACCW-1:0]    r_acc;
    logic [ACCW-1:0]           r_out_data;
    logic                      r_out_valid;

    logic signed [DW-1:0]      w_d;
    logic signed [DW-1:0]      w_k;
    logic signed [2*DW-1:0]    w_prod;
    logic signed [ACCW-1:0]    w_prod_ext;
    logic signed [ACCW-1:0]    w_sum;

    // Current tap operands come from the latched copies, so upstream may change its bus freely.
    assign w_d        = r_data[r_idx*DW +: DW];
    assign w_k        = r_kernel[r_idx*DW +: DW];
    assign w_prod     = w_d * w_k;
    assign w_prod_ext = ACCW'(w_prod);
    assign w_sum      = r_acc + w_prod_ext;

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept in IDLE, run LEN accumulate cycles, then wait for the sink.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid && w_in_ready) w_next = S_CALC;
            S_CALC:  if (r_idx == LAST_IDX)      w_next = S_DONE;
            S_DONE:  if (out_ready)              w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: ready only in IDLE and never while reset is asserted.
    always_comb begin
        w_in_ready = 1'b0;
        if (r_state == S_IDLE && !rst) begin
            w_in_ready = 1'b1;
        end
    end

    // Datapath: latch window, accumulate in index order, publish and hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_kernel    <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data   <= in_data;
                        r_kernel <= in_kernel;
                        r_acc    <= '0;
                        r_idx    <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + IW'(1);
                    if (r_idx == LAST_IDX) begin
                        r_out_data  <= w_sum;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
